control_unit: RTL and testbench
===============================

# control_unit

Central control unit of the ultrasonic Zynq-7000 front end. It accepts decoded orders (on/off, increase/decrease power by an amount, send/receive mode) qualified by a valid strobe, holds the 12-bit DAC power level, and moves 25-bit words from the receive buffer to the AXI side. It sits between the command decoder and buffer on one side and the DAC and AXI interface on the other.

## Interface
Parameters: none. Widths are fixed: 8-bit amount, 25-bit data, 12-bit DAC.

Ports, one per line (name, direction, width, meaning):
- `clk` — in, 1 — single system clock, rising-edge.
- `rst_n` — in, 1 — asynchronous, active-low reset.
- `ValidSignal` — in, 1 — decoder strobe; all order inputs are ignored when it is low.
- `onSignal` — in, 1 — power-on order.
- `offSignal` — in, 1 — power-off order; wins over `onSignal`.
- `increaseSignal` — in, 1 — raise the DAC level.
- `decreaseSignal` — in, 1 — lower the DAC level.
- `AmountSignal` — in, 8 — step count for increase or decrease.
- `sendEnable` — in, 1 — send (DAC-configuration) mode.
- `rec_en` — in, 1 — receive mode.
- `buf_in` — in, 25 — data word from the buffer.
- `send_enB` — out, 1 — request to the buffer to present data.
- `sending` — out, 1 — transfer-in-progress flag.
- `AXI_OUT` — out, 25 — data word forwarded to AXI.
- `no_order` — out, 1 — high when no active order is in force.
- `outputDAC` — out, 12 — DAC power level.

## Operation
All state is registered on the rising edge of `clk`. There are two states, `OFF` and `ON`.

Order qualification:
- An input is a qualified command only when `ValidSignal` is 1.
- Qualified `offSignal` → state `OFF`. Qualified `onSignal` without `offSignal` → state `ON`.

In state `OFF`:
- `outputDAC` = 0, `AXI_OUT` = 0, `sending` = 0, `send_enB` = 0, `no_order` = 1.
- Increase, decrease and transfer requests are ignored.

In state `ON`:
- `no_order` = 0.
- DAC step is `AmountSignal << 4`, zero-extended to 12 bits (amount 1 → 0x010).
- Increase: `outputDAC` ← min(`outputDAC` + step, 0xFFF).
- Decrease: `outputDAC` ← max(`outputDAC` − step, 0).
- An adjustment fires once, in the cycle after the qualified `increaseSignal` or `decreaseSignal` goes from 0 to 1 (edge-detected). Holding the signal high does not repeat it.
- If increase and decrease rise in the same cycle, neither adjustment is applied.
- Transfer mode is `rec_en`=1 and `sendEnable`=0 (ValidSignal not required once `ON`). In transfer mode every cycle: `send_enB` = 1, `sending` = 1, `AXI_OUT` ← `buf_in` (all 25 bits).
- Outside transfer mode: `send_enB` = 0, `sending` = 0, `AXI_OUT` holds its last value.
- `sendEnable`=1 blocks transfer regardless of `rec_en`.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low): state `OFF`, `no_order` = 1, `outputDAC` = 0, `AXI_OUT` = 0, `sending` = 0, `send_enB` = 0, edge-detect registers cleared.
- All outputs are registered. Latency from an input sampled at edge N to the corresponding output is visible after edge N, i.e. 1 cycle.
- An off order takes effect in 1 cycle. It clears `outputDAC` and `AXI_OUT` and drops a transfer already in progress.
- An on order followed by an increase in the same cycle: the state is updated first, and the increase is applied in that same cycle as a 0→1 edge.
- Reset asserted mid-transfer clears all outputs immediately. Operation resumes only after a new on order.
- DAC arithmetic is done at 13 bits, then saturated. The value never wraps.

## Structure
- Package `control_unit_pkg` holds:
  - `typedef enum logic {OFF, ON} cu_state_t`
  - constants `DATA_W`=25, `DAC_W`=12, `AMT_W`=8, `DAC_SHIFT`=4, `DAC_MAX`=12'hFFF.
- Sub-module `dac_level_reg` holds the saturating 12-bit accumulator with increase/decrease edge detection and a synchronous clear on `OFF`.
- The top level holds the state register, order qualification and the transfer datapath.

## Test plan
1. Reset: hold `rst_n`=0 with all inputs 0 → `no_order`=1, `AXI_OUT`=0, `outputDAC`=0, `sending`=0.
2. No order: release reset, set `rec_en`=1, `buf_in`=0x0FFFFFF, `ValidSignal`=0 → `AXI_OUT` stays 0, `sending`=0, `no_order`=1.
3. Off: `ValidSignal`=1, `offSignal`=1 (with or without `onSignal`) → `outputDAC`=0x000, `no_order`=1.
4. On and increase: `ValidSignal`=1, `onSignal`=1, `AmountSignal`=1, then raise `increaseSignal` → `outputDAC`=0x010 one cycle later, and it stays 0x010 while the signal is held. Then set `rec_en`=1, `sendEnable`=0, `buf_in`=0x1FFFFFF → the next cycle gives `sending`=1, `send_enB`=1, `AXI_OUT`=0x1FFFFFF.
5. Decrease and saturation:
   - From 0x010, `AmountSignal`=1, raise `decreaseSignal` → `outputDAC`=0x000.
   - Repeat the decrease → stays 0x000.
   - `AmountSignal`=0xFF with two increase pulses → 0xFF0, then 0xFFF (saturated).
6. Mid-transfer: while transferring `buf_in`=0x0EEEEEE, pulse `rst_n` low → all outputs return to reset values at once, and the next transfer requires a new on order.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared types and widths for the ultrasonic front-end control unit.
// The DAC step helper keeps the amount-to-code scaling in one place.
package control_unit_pkg;

   typedef enum logic {OFF = 1'b0, ON = 1'b1} cu_state_t;

   localparam int DATA_W    = 25;
   localparam int DAC_W     = 12;
   localparam int AMT_W     = 8;
   localparam int DAC_SHIFT = 4;

   localparam logic [DAC_W-1:0] DAC_MAX = 12'hFFF;

   // One amount unit equals 16 DAC codes; 8 + 4 bits fill the 12-bit DAC exactly.
   function automatic logic [DAC_W-1:0] dac_step(input logic [AMT_W-1:0] amount);
      return {amount, {DAC_SHIFT{1'b0}}};
   endfunction

endpackage

// File: rtl/dac_level_reg.sv
// Saturating DAC power-level accumulator with rising-edge detection on the
// increase/decrease orders and a synchronous clear while the unit is off.
module dac_level_reg
   import control_unit_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_inc,
   input  logic             i_dec,
   input  logic [AMT_W-1:0] i_amount,
   output logic [DAC_W-1:0] o_level
);

   logic             r_inc_d;
   logic             r_dec_d;
   logic [DAC_W-1:0] r_level;

   logic             w_inc_rise;
   logic             w_dec_rise;
   logic [DAC_W-1:0] w_step;
   logic [DAC_W:0]   w_sum;
   logic [DAC_W:0]   w_diff;
   logic [DAC_W-1:0] w_level_nxt;

   assign w_inc_rise = i_inc & ~r_inc_d;
   assign w_dec_rise = i_dec & ~r_dec_d;
   assign w_step     = dac_step(i_amount);

   // Extra MSB on both paths: carry means overflow, borrow means underflow.
   assign w_sum  = {1'b0, r_level} + {1'b0, w_step};
   assign w_diff = {1'b0, r_level} - {1'b0, w_step};

   always_comb begin
      w_level_nxt = r_level;
      if (i_clear) begin
         w_level_nxt = '0;
      end else if (w_inc_rise && !w_dec_rise) begin
         w_level_nxt = w_sum[DAC_W] ? DAC_MAX : w_sum[DAC_W-1:0];
      end else if (w_dec_rise && !w_inc_rise) begin
         w_level_nxt = w_diff[DAC_W] ? '0 : w_diff[DAC_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inc_d <= 1'b0;
         r_dec_d <= 1'b0;
         r_level <= '0;
      end else begin
         r_inc_d <= i_inc;
         r_dec_d <= i_dec;
         r_level <= w_level_nxt;
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/control_unit.sv
// Central control unit: on/off state, DAC level control and buffer-to-AXI
// transfer. All outputs are registered from the next-state decision.
//
//   state | meaning
//   OFF   | idle; DAC and AXI word forced to 0, no transfer, no_order high
//   ON    | DAC adjustable, transfers run while rec_en=1 and sendEnable=0
module control_unit
   import control_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ValidSignal,
   input  logic              onSignal,
   input  logic              offSignal,
   input  logic              increaseSignal,
   input  logic              decreaseSignal,
   input  logic [AMT_W-1:0]  AmountSignal,
   input  logic              sendEnable,
   input  logic              rec_en,
   input  logic [DATA_W-1:0] buf_in,
   output logic              send_enB,
   output logic              sending,
   output logic [DATA_W-1:0] AXI_OUT,
   output logic              no_order,
   output logic [DAC_W-1:0]  outputDAC
);

   cu_state_t         r_state;
   cu_state_t         w_state_nxt;
   logic              r_send_enB;
   logic              r_sending;
   logic              r_no_order;
   logic [DATA_W-1:0] r_axi;

   logic              w_on_cmd;
   logic              w_off_cmd;
   logic              w_xfer;
   logic              w_sending_nxt;
   logic              w_no_order_nxt;
   logic [DATA_W-1:0] w_axi_nxt;
   logic [DAC_W-1:0]  w_dac_level;

   assign w_off_cmd = ValidSignal & offSignal;
   assign w_on_cmd  = ValidSignal & onSignal & ~offSignal;

   always_comb begin
      w_state_nxt    = r_state;
      w_sending_nxt  = 1'b0;
      w_axi_nxt      = r_axi;
      w_no_order_nxt = 1'b1;
      w_xfer         = 1'b0;

      if (w_off_cmd) begin
         w_state_nxt = OFF;
      end else if (w_on_cmd) begin
         w_state_nxt = ON;
      end

      // Outputs follow the state being entered, so an off order drops a
      // transfer on the same edge and an on order can start one.
      case (w_state_nxt)
         OFF: begin
            w_axi_nxt = '0;
         end
         ON: begin
            w_no_order_nxt = 1'b0;
            w_xfer         = rec_en & ~sendEnable;
            if (w_xfer) begin
               w_sending_nxt = 1'b1;
               w_axi_nxt     = buf_in;
            end
         end
         default: begin
            w_axi_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= OFF;
         r_send_enB <= 1'b0;
         r_sending  <= 1'b0;
         r_no_order <= 1'b1;
         r_axi      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_send_enB <= w_sending_nxt;
         r_sending  <= w_sending_nxt;
         r_no_order <= w_no_order_nxt;
         r_axi      <= w_axi_nxt;
      end
   end

   dac_level_reg u_dac_level_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (w_state_nxt == OFF),
      .i_inc    (ValidSignal & increaseSignal),
      .i_dec    (ValidSignal & decreaseSignal),
      .i_amount (AmountSignal),
      .o_level  (w_dac_level)
   );

   assign send_enB  = r_send_enB;
   assign sending   = r_sending;
   assign AXI_OUT   = r_axi;
   assign no_order  = r_no_order;
   assign outputDAC = w_dac_level;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: one table row per clock cycle,
// followed by a hand-written mid-transfer reset sequence.
module tb_control_unit;

   logic        clk;
   logic        rst_n;
   logic        ValidSignal;
   logic        onSignal;
   logic        offSignal;
   logic        increaseSignal;
   logic        decreaseSignal;
   logic [7:0]  AmountSignal;
   logic        sendEnable;
   logic        rec_en;
   logic [24:0] buf_in;
   logic        send_enB;
   logic        sending;
   logic [24:0] AXI_OUT;
   logic        no_order;
   logic [11:0] outputDAC;

   control_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ValidSignal    (ValidSignal),
      .onSignal       (onSignal),
      .offSignal      (offSignal),
      .increaseSignal (increaseSignal),
      .decreaseSignal (decreaseSignal),
      .AmountSignal   (AmountSignal),
      .sendEnable     (sendEnable),
      .rec_en         (rec_en),
      .buf_in         (buf_in),
      .send_enB       (send_enB),
      .sending        (sending),
      .AXI_OUT        (AXI_OUT),
      .no_order       (no_order),
      .outputDAC      (outputDAC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctl  = {valid, on, off, inc, dec, sendEnable, rec_en}
   // ectl = {send_enB, sending, no_order}
   typedef struct {
      logic [6:0]  ctl;
      logic [7:0]  amt;
      logic [24:0] bufin;
      logic [2:0]  ectl;
      logic [24:0] eaxi;
      logic [11:0] edac;
   } vec_t;

   localparam int NVEC = 24;
   vec_t vecs [NVEC];

   int n_vec;
   int n_miss;

   task automatic drive(input logic [6:0] ctl, input logic [7:0] amt, input logic [24:0] bufin);
      ValidSignal    = ctl[6];
      onSignal       = ctl[5];
      offSignal      = ctl[4];
      increaseSignal = ctl[3];
      decreaseSignal = ctl[2];
      sendEnable     = ctl[1];
      rec_en         = ctl[0];
      AmountSignal   = amt;
      buf_in         = bufin;
   endtask

   task automatic check(input string name, input logic [2:0] ectl,
                        input logic [24:0] eaxi, input logic [11:0] edac);
      logic [2:0] actl;
      actl = {send_enB, sending, no_order};
      n_vec++;
      if (actl !== ectl || AXI_OUT !== eaxi || outputDAC !== edac) begin
         n_miss++;
         $display("FAIL %s: got enb/sending/no_order=%b axi=%h dac=%h, want %b axi=%h dac=%h",
                  name, actl, AXI_OUT, outputDAC, ectl, eaxi, edac);
      end
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;

      vecs[0]  = '{7'b0000000, 8'h00, 25'h0000000, 3'b001, 25'h0000000, 12'h000};
      vecs[1]  = '{7'b0000001, 8'h00, 25'h0FFFFFF, 3'b001, 25'h0000000, 12'h000};
      vecs[2]  = '{7'b1110000, 8'h00, 25'h0000000, 3'b001, 25'h0000000, 12'h000};
      vecs[3]  = '{7'b1100000, 8'h01, 25'h0000000, 3'b000, 25'h0000000, 12'h000};
      vecs[4]  = '{7'b1001000, 8'h01, 25'h0000000, 3'b000, 25'h0000000, 12'h010};
      vecs[5]  = '{7'b1001000, 8'h01, 25'h0000000, 3'b000, 25'h0000000, 12'h010};
      vecs[6]  = '{7'b0000001, 8'h01, 25'h1FFFFFF, 3'b110, 25'h1FFFFFF, 12'h010};
      vecs[7]  = '{7'b0000011, 8'h01, 25'h0123456, 3'b000, 25'h1FFFFFF, 12'h010};
      vecs[8]  = '{7'b0000000, 8'h01, 25'h0000000, 3'b000, 25'h1FFFFFF, 12'h010};
      vecs[9]  = '{7'b1000100, 8'h01, 25'h0000000, 3'b000, 25'h1FFFFFF, 12'h000};
      vecs[10] = '{7'b1000000, 8'h01, 25'h0000000, 3'b000, 25'h1FFFFFF, 12'h000};
      vecs[11] = '{7'b1000100, 8'h01, 25'h0000000, 3'b000, 25'h1FFFFFF, 12'h000};
      vecs[12] = '{7'b1000000, 8'hFF, 25'h0000000, 3'b000, 25'h1FFFFFF, 12'h000};
      vecs[13] = '{7'b1001000, 8'hFF, 25'h0000000, 3'b000, 25'h1FFFFFF, 12'hFF0};
      vecs[14] = '{7'b1000000, 8'hFF, 25'h0000000, 3'b000, 25'h1FFFFFF, 12'hFF0};
      vecs[15] = '{7'b1001000, 8'hFF, 25'h0000000, 3'b000, 25'h1FFFFFF, 12'hFFF};
      vecs[16] = '{7'b1000000, 8'h01, 25'h0000000, 3'b000, 25'h1FFFFFF, 12'hFFF};
      vecs[17] = '{7'b1001100, 8'h01, 25'h0000000, 3'b000, 25'h1FFFFFF, 12'hFFF};
      vecs[18] = '{7'b0000000, 8'h10, 25'h0000000, 3'b000, 25'h1FFFFFF, 12'hFFF};
      vecs[19] = '{7'b1000100, 8'h10, 25'h0000000, 3'b000, 25'h1FFFFFF, 12'hEFF};
      vecs[20] = '{7'b0000001, 8'h10, 25'h0EEEEEE, 3'b110, 25'h0EEEEEE, 12'hEFF};
      vecs[21] = '{7'b1010001, 8'h00, 25'h0EEEEEE, 3'b001, 25'h0000000, 12'h000};
      vecs[22] = '{7'b0100001, 8'h00, 25'h0EEEEEE, 3'b001, 25'h0000000, 12'h000};
      vecs[23] = '{7'b1101001, 8'h02, 25'h0ABCDEF, 3'b110, 25'h0ABCDEF, 12'h020};

      rst_n = 1'b0;
      drive(7'b0000000, 8'h00, 25'h0);
      #12;
      check("reset_hold", 3'b001, 25'h0, 12'h000);

      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive(vecs[i].ctl, vecs[i].amt, vecs[i].bufin);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), vecs[i].ectl, vecs[i].eaxi, vecs[i].edac);
      end

      // Transfer in progress, then asynchronous reset between clock edges.
      @(negedge clk);
      drive(7'b0000001, 8'h00, 25'h0EEEEEE);
      @(posedge clk);
      #1;
      check("xfer_before_reset", 3'b110, 25'h0EEEEEE, 12'h020);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_midxfer", 3'b001, 25'h0, 12'h000);

      @(negedge clk);
      rst_n = 1'b1;
      drive(7'b0000001, 8'h00, 25'h0EEEEEE);
      @(posedge clk);
      #1;
      check("after_reset_no_on", 3'b001, 25'h0, 12'h000);

      @(negedge clk);
      drive(7'b1100001, 8'h00, 25'h0EEEEEE);
      @(posedge clk);
      #1;
      check("reon_resumes_xfer", 3'b110, 25'h0EEEEEE, 12'h000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
